// File: rtl/timer_pkg.sv
// Shared types and constants for bus_timer: FSM states, register offsets,
// CTRL field positions, MODE encodings and the byte-lane merge helper.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_INT
  } state_e;

  localparam logic [31:0] CTRL_OFF   = 32'h0000_0000;
  localparam logic [31:0] PRESET_OFF = 32'h0000_0004;
  localparam logic [31:0] COUNT_OFF  = 32'h0000_0008;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_timer_if.sv
// CPU data-bus bundle for bus_timer: byte-addressed access, per-lane write
// enables, combinational read data and the interrupt line.
interface bus_timer_if;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, byteen, wdata, input rdata, irq);
  modport slave  (input addr, byteen, wdata, output rdata, irq);
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped down-counter with CTRL/PRESET/COUNT registers and a maskable irq.
// Define TIMER_AUTO_RELOAD_EN to enable MODE=1 (periodic auto-reload).
module bus_timer
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7f00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [31:0] CTRL_ADDR   = BASE_ADDR + CTRL_OFF;
  localparam logic [31:0] PRESET_ADDR = BASE_ADDR + PRESET_OFF;
  localparam logic [31:0] COUNT_ADDR  = BASE_ADDR + COUNT_OFF;

  state_e      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;

  logic        sel_ctrl, sel_preset, sel_count;
  logic        wr_ctrl, wr_preset, reload;
  logic [31:0] ctrl_rd, ctrl_fsm, ctrl_wr;
  logic        unused_bits;

  assign sel_ctrl   = (addr[31:2] == CTRL_ADDR[31:2]);
  assign sel_preset = (addr[31:2] == PRESET_ADDR[31:2]);
  assign sel_count  = (addr[31:2] == COUNT_ADDR[31:2]);
  assign wr_ctrl    = sel_ctrl   && (byteen != 4'b0000);
  assign wr_preset  = sel_preset && (byteen != 4'b0000);
  assign reload     = (mode_q == MODE_RELOAD);

  always_comb begin
    ctrl_rd                          = '0;
    ctrl_rd[CTRL_EN_BIT]             = en_q;
    ctrl_rd[CTRL_MODE_LSB +: 2]      = mode_q;
    ctrl_rd[CTRL_IM_BIT]             = im_q;
  end

  always_comb begin
    rdata = '0;
    if (sel_ctrl)        rdata = ctrl_rd;
    else if (sel_preset) rdata = preset_q;
    else if (sel_count)  rdata = count_q;
  end

  assign irq = im_q & pend_q;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    preset_d = preset_q;
    count_d  = count_q;
    pend_d   = pend_q;

    case (state_q)
      ST_IDLE: begin
        if (en_q) begin
          state_d = ST_LOAD;
          pend_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en_q) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // PRESET=0 lands here too, so it behaves like PRESET=1 and never wraps.
          count_d = '0;
          pend_d  = 1'b1;
          state_d = ST_INT;
        end
      end
      ST_INT: begin
        state_d = ST_IDLE;
        if (reload) pend_d = 1'b0;
        else        en_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus writes are merged over the FSM's CTRL result, so a CPU write wins.
    ctrl_fsm                     = '0;
    ctrl_fsm[CTRL_EN_BIT]        = en_d;
    ctrl_fsm[CTRL_MODE_LSB +: 2] = mode_d;
    ctrl_fsm[CTRL_IM_BIT]        = im_d;
    ctrl_wr = byte_merge(ctrl_fsm, wdata, byteen);

    if (wr_ctrl) begin
      en_d = ctrl_wr[CTRL_EN_BIT];
      im_d = ctrl_wr[CTRL_IM_BIT];
`ifdef TIMER_AUTO_RELOAD_EN
      mode_d = ctrl_wr[CTRL_MODE_LSB +: 2];
`endif
    end

    if (wr_preset) preset_d = byte_merge(preset_q, wdata, byteen);
  end

  assign unused_bits = ^{addr[1:0], ctrl_wr[31:4], ctrl_wr[2:1]};

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      mode_q   <= MODE_ONESHOT;
      im_q     <= 1'b0;
      preset_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

endmodule
